// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Digit-serial subtractor: Difference = InputA - InputB - InputBorrow,
//   processed DIGIT bits per clock, LSB first, over N = WIDTH/DIGIT cycles.
//   The results are registered and change only on the completion edge.
//
// Ports
//   Clock         rising-edge clock
//   nReset        asynchronous active-low reset
//   Start         request, sampled only while not in RUN
//   InputA        minuend (WIDTH)
//   InputB        subtrahend (WIDTH)
//   InputBorrow   borrow-in
//   Difference    registered result (WIDTH)
//   OutputBorrow  registered borrow-out (unsigned A < B + InputBorrow)
//   Overflow      registered two's-complement overflow
//   Busy          high while in RUN
//   Done          one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for Start, last result held on outputs
// RUN   | one digit subtracted per edge, N edges total
// DONE  | single-cycle completion; Start here chains straight into RUN

module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             Start,
  input  logic [WIDTH-1:0] InputA,
  input  logic [WIDTH-1:0] InputB,
  input  logic             InputBorrow,
  output logic [WIDTH-1:0] Difference,
  output logic             OutputBorrow,
  output logic             Overflow,
  output logic             Busy,
  output logic             Done
);

  if ((WIDTH % DIGIT) != 0) begin : gDigitCheck
    $error("serial_subtractor: DIGIT must divide WIDTH");
  end

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateType;

  stateType state;
  stateType nextState;

  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] resultReg;
  logic             borrowReg;
  logic [CNT_W-1:0] digitCnt;
  logic             signA;
  logic             signB;

  logic [DIGIT:0]   digitDiff;
  logic [WIDTH-1:0] nextResult;
  logic             lastDigit;
  logic             acceptStart;

  // Operands are zero-extended by one bit, so the top bit of the
  // difference is set exactly when the digit subtraction goes negative,
  // i.e. it is the borrow out of this digit.
  assign digitDiff = {1'b0, opA[DIGIT-1:0]} - {1'b0, opB[DIGIT-1:0]}
                   - {{DIGIT{1'b0}}, borrowReg};

  // New digit enters from the top; the whole register moves down by DIGIT.
  assign nextResult  = WIDTH'({digitDiff[DIGIT-1:0], resultReg} >> DIGIT);
  assign lastDigit   = (digitCnt == LAST_CNT);
  assign acceptStart = Start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE: begin
        if (Start) nextState = RUN;
      end
      RUN: begin
        Busy = 1'b1;
        if (lastDigit) nextState = DONE;
      end
      DONE: begin
        Done      = 1'b1;
        nextState = Start ? RUN : IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      opA          <= '0;
      opB          <= '0;
      resultReg    <= '0;
      borrowReg    <= 1'b0;
      digitCnt     <= '0;
      signA        <= 1'b0;
      signB        <= 1'b0;
      Difference   <= '0;
      OutputBorrow <= 1'b0;
      Overflow     <= 1'b0;
    end else if (acceptStart) begin
      opA       <= InputA;
      opB       <= InputB;
      borrowReg <= InputBorrow;
      resultReg <= '0;
      digitCnt  <= '0;
      // Sign bits are kept aside because the operand registers shift away.
      signA     <= InputA[WIDTH-1];
      signB     <= InputB[WIDTH-1];
    end else if (state == RUN) begin
      opA       <= opA >> DIGIT;
      opB       <= opB >> DIGIT;
      borrowReg <= digitDiff[DIGIT];
      resultReg <= nextResult;
      digitCnt  <= digitCnt + 1'b1;
      if (lastDigit) begin
        Difference   <= nextResult;
        OutputBorrow <= digitDiff[DIGIT];
        Overflow     <= (signA != signB) && (nextResult[WIDTH-1] != signA);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Drives four serial_subtractor instances (DIGIT = 1, 2, 4, 8 with
//   WIDTH = 8) from shared operands and compares them with an arithmetic
//   reference of A - B - borrow.

module tb_serial_subtractor;

  logic       Clock = 1'b0;
  logic       nReset;
  logic [3:0] startV;
  logic [7:0] InputA;
  logic [7:0] InputB;
  logic       InputBorrow;

  logic [7:0] diffV   [4];
  logic       borrowV [4];
  logic       ovfV    [4];
  logic       busyV   [4];
  logic       doneV   [4];

  int errCount   = 0;
  int checkCount = 0;

  for (genvar g = 0; g < 4; g++) begin : gDut
    serial_subtractor #(.WIDTH(8), .DIGIT(1 << g)) uDut (
      .Clock       (Clock),
      .nReset      (nReset),
      .Start       (startV[g]),
      .InputA      (InputA),
      .InputB      (InputB),
      .InputBorrow (InputBorrow),
      .Difference  (diffV[g]),
      .OutputBorrow(borrowV[g]),
      .Overflow    (ovfV[g]),
      .Busy        (busyV[g]),
      .Done        (doneV[g])
    );
  end

  always #5 Clock = ~Clock;

  task automatic checkVal(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void refSub(input logic [7:0] a, input logic [7:0] b,
                                 input logic bin, output logic [7:0] d,
                                 output logic bo, output logic ov);
    int r;
    int sr;
    r  = int'(a) - int'(b) - int'(bin);
    sr = int'($signed(a)) - int'($signed(b)) - int'(bin);
    d  = 8'(r);
    bo = (r < 0);
    ov = (sr > 127) || (sr < -128);
  endfunction

  // One operation on every instance selected by mask; a fixed window long
  // enough for DIGIT=1 bounds the wait and also catches stray pulses.
  task automatic runOp(input logic [3:0] mask, input logic [7:0] a,
                       input logic [7:0] b, input logic bin, input string tag);
    logic [7:0] expD;
    logic       expB;
    logic       expO;
    int         doneCnt [4];
    int         doneAt  [4];
    int         busyCnt [4];
    logic [7:0] gotD    [4];
    logic       gotB    [4];
    logic       gotO    [4];
    logic [7:0] prevD   [4];
    logic       holdBad [4];
    refSub(a, b, bin, expD, expB, expO);
    @(negedge Clock);
    InputA      = a;
    InputB      = b;
    InputBorrow = bin;
    startV      = mask;
    for (int i = 0; i < 4; i++) begin
      prevD[i]   = diffV[i];
      doneCnt[i] = 0;
      doneAt[i]  = -1;
      busyCnt[i] = 0;
      gotD[i]    = '0;
      gotB[i]    = 1'b0;
      gotO[i]    = 1'b0;
      holdBad[i] = 1'b0;
    end
    @(negedge Clock);
    startV = '0;
    for (int j = 0; j < 12; j++) begin
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) begin
          if (doneV[i]) begin
            doneCnt[i]++;
            if (doneAt[i] < 0) begin
              doneAt[i] = j;
              gotD[i]   = diffV[i];
              gotB[i]   = borrowV[i];
              gotO[i]   = ovfV[i];
            end
          end
          if (busyV[i]) busyCnt[i]++;
          if (doneAt[i] < 0 && diffV[i] !== prevD[i]) holdBad[i] = 1'b1;
        end
      end
      @(negedge Clock);
    end
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        checkVal($sformatf("%s d%0d doneCount", tag, 1 << i), doneCnt[i], 1);
        checkVal($sformatf("%s d%0d latency", tag, 1 << i), doneAt[i], 8 >> i);
        checkVal($sformatf("%s d%0d busyCycles", tag, 1 << i), busyCnt[i], 8 >> i);
        checkVal($sformatf("%s d%0d hold", tag, 1 << i), 32'(holdBad[i]), 0);
        checkVal($sformatf("%s d%0d diff", tag, 1 << i), 32'(gotD[i]), 32'(expD));
        checkVal($sformatf("%s d%0d borrow", tag, 1 << i), 32'(gotB[i]), 32'(expB));
        checkVal($sformatf("%s d%0d ovf", tag, 1 << i), 32'(gotO[i]), 32'(expO));
      end
    end
  endtask

  initial begin
    int doneCnt;
    int t1;
    int t2;
    nReset      = 1'b0;
    startV      = '0;
    InputA      = '0;
    InputB      = '0;
    InputBorrow = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    for (int i = 0; i < 4; i++) begin
      checkVal($sformatf("reset d%0d diff", 1 << i), 32'(diffV[i]), 0);
      checkVal($sformatf("reset d%0d borrow", 1 << i), 32'(borrowV[i]), 0);
      checkVal($sformatf("reset d%0d ovf", 1 << i), 32'(ovfV[i]), 0);
      checkVal($sformatf("reset d%0d busy", 1 << i), 32'(busyV[i]), 0);
      checkVal($sformatf("reset d%0d done", 1 << i), 32'(doneV[i]), 0);
    end
    nReset = 1'b1;
    repeat (3) @(negedge Clock);
    checkVal("idle no start busy", 32'(busyV[0]), 0);

    runOp(4'hF, 8'd12, 8'd5, 1'b0, "t1 12-5");
    runOp(4'hF, 8'd5, 8'd12, 1'b0, "t2 5-12");
    runOp(4'hF, 8'h80, 8'h01, 1'b0, "t3 80-01");
    runOp(4'hF, 8'h00, 8'h00, 1'b1, "t3 0-0-1");
    runOp(4'hF, 8'h3C, 8'hC3, 1'b0, "t6 3C-C3");
    runOp(4'hF, 8'h7F, 8'hFF, 1'b0, "edge 7F-FF");
    runOp(4'hF, 8'hFF, 8'hFF, 1'b1, "edge FF-FF-1");

    // Start and input changes during RUN must not disturb the operation.
    @(negedge Clock);
    InputA = 8'd12; InputB = 8'd5; InputBorrow = 1'b0; startV = 4'b0001;
    @(negedge Clock);
    startV = '0;
    @(negedge Clock);
    @(negedge Clock);
    InputA = 8'd1; InputB = 8'd1; startV = 4'b0001;
    @(negedge Clock);
    startV = '0;
    doneCnt = 0;
    for (int j = 0; j < 14; j++) begin
      if (doneV[0]) doneCnt++;
      @(negedge Clock);
    end
    checkVal("t4 single done", doneCnt, 1);
    checkVal("t4 diff", 32'(diffV[0]), 7);
    checkVal("t4 idle after", 32'(busyV[0]), 0);

    // Start held high: back-to-back operations.
    @(negedge Clock);
    InputA = 8'd12; InputB = 8'd5; startV = 4'b0001;
    t1 = -1;
    t2 = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge Clock);
      if (doneV[0]) begin
        if (t1 < 0) t1 = c;
        else if (t2 < 0) t2 = c;
      end
    end
    startV = '0;
    repeat (12) @(negedge Clock);
    checkVal("t4 b2b first done", t1, 8);
    checkVal("t4 b2b spacing", t2 - t1, 9);
    checkVal("t4 b2b diff", 32'(diffV[0]), 7);

    // Asynchronous reset in the middle of RUN.
    @(negedge Clock);
    InputA = 8'd20; InputB = 8'd3; startV = 4'b0001;
    @(negedge Clock);
    startV = '0;
    @(negedge Clock);
    @(negedge Clock);
    checkVal("t5 busy before rst", 32'(busyV[0]), 1);
    checkVal("t5 held diff", 32'(diffV[0]), 7);
    #2 nReset = 1'b0;
    #1;
    checkVal("t5 rst busy", 32'(busyV[0]), 0);
    checkVal("t5 rst done", 32'(doneV[0]), 0);
    checkVal("t5 rst diff", 32'(diffV[0]), 0);
    checkVal("t5 rst borrow", 32'(borrowV[0]), 0);
    checkVal("t5 rst ovf", 32'(ovfV[0]), 0);
    @(negedge Clock);
    @(negedge Clock);
    nReset = 1'b1;
    runOp(4'b0001, 8'd20, 8'd3, 1'b0, "t5 after rst");

    for (int v = 0; v < 1000; v++) begin
      runOp(4'hF, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Multi-cycle, digit-serial subtractor computing InputA - InputB - InputBorrow. It is the inverse operation of the combinational carry-lookahead adder. It trades area for latency by processing DIGIT bits per clock, LSB first. A start/busy/done handshake lets it sit on shared ALU datapaths and be cross-checked against the adder (A = Difference + B + borrow).

Parameters:
WIDTH, 8, operand and result width in bits.
DIGIT, 1, bits processed per clock; must divide WIDTH (elaboration error otherwise).

Ports:
Clock  input  1  rising-edge clock.
nReset  input  1  asynchronous, active-low reset.
Start  input  1  request; sampled only when Busy=0.
InputA  input  WIDTH  minuend.
InputB  input  WIDTH  subtrahend.
InputBorrow  input  1  borrow-in.
Difference  output  WIDTH  registered result.
OutputBorrow  output  1  registered borrow-out (1 when unsigned A < B + InputBorrow).
Overflow  output  1  registered signed (two's-complement) overflow.
Busy  output  1  high while in RUN.
Done  output  1  one-cycle completion pulse.

Behaviour:
- Interface: one clock (Clock); reset is asynchronous and active-low (nReset).
- Reset (nReset=0, asynchronous): state IDLE; Difference=0, OutputBorrow=0, Overflow=0, Busy=0, Done=0; internal operand/shift registers and digit counter cleared.
- N = WIDTH/DIGIT iterations.
- States: IDLE, RUN, DONE.
- IDLE: on an edge with Start=1, latch InputA, InputB and InputBorrow; counter=0; go to RUN. Start=0 stays in IDLE.
- RUN: Busy=1. Each edge computes {borrow, d} = a_digit - b_digit - borrow_reg on the low DIGIT bits of the latched operands. The operands shift right by DIGIT; d shifts into the result register from the top; counter increments.
- RUN exit: after the Nth RUN edge, go to DONE. On that same edge, load Difference, OutputBorrow and Overflow from the final internal values.
- Overflow = (A[MSB] != B[MSB]) && (Difference[MSB] != A[MSB]), using the latched A and B.
- DONE: lasts exactly one cycle with Done=1 and Busy=0. Next state is RUN if Start=1 on that edge (new operands latched), else IDLE.
- Latency: Start sampled at edge k; Busy=1 from edge k to edge k+N; Done=1 from edge k+N to edge k+N+1. Throughput is one operation per N+1 cycles.
- Outputs Difference, OutputBorrow and Overflow hold the last completed result through IDLE and a following RUN. They never show partial values and change only on the completion edge.
- Start while Busy=1 is ignored; it is neither queued nor allowed to corrupt the operation in progress.
- Input changes during RUN have no effect, since operands are latched.
- Wrap-around is modulo 2^WIDTH, e.g. 0 - 1 = all ones with OutputBorrow=1.
- Reset asserted mid-RUN aborts the operation immediately: Busy=0, outputs zeroed, no Done pulse.
- Release of reset is synchronous to operation: the first Start is sampled at the first rising edge with nReset=1.

Test Plan:
1. WIDTH=8, DIGIT=1: A=12, B=5, borrow=0, Start for one cycle -> after 8 edges Done pulses once; Difference=7, OutputBorrow=0, Overflow=0; Busy high for exactly 8 cycles.
2. A=5, B=12, borrow=0 -> Difference=249 (0xF9), OutputBorrow=1, Overflow=0. Cross-check with the adder: 249 + 12 = 5 with carry 1.
3. A=0x80, B=0x01 -> Difference=0x7F, OutputBorrow=0, Overflow=1. Also A=0, B=0, borrow=1 -> Difference=0xFF, OutputBorrow=1, Overflow=0.
4. Pulse Start with A=12, B=5. Then on RUN cycle 3, change the inputs to A=1, B=1 and pulse Start -> result is still 7, exactly one Done pulse, no second operation. Holding Start high through DONE launches back-to-back operations, with Done spaced 9 cycles apart.
5. After a completed 7-result, start 20-3 and drop nReset low mid-RUN for 2 cycles -> Busy, Done and outputs go to 0 immediately with no clock edge required. The next Start of 20-3 gives 17 with normal latency.
6. DIGIT=4 (and DIGIT=8): A=0x3C, B=0xC3 -> Difference=0x79, OutputBorrow=1, Overflow=0. Done arrives 2 cycles (respectively 1 cycle) after the Start edge. A 1000-vector random sweep matches the reference model A-B-borrow for DIGIT in {1, 2, 4, 8}.
